axi_mem_subordinate: RTL and testbench



---
 rtl/axi_mem_subordinate.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_mem_subordinate.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_subordinate.sv
// AXI4 subordinate backed by a 32-bit word-addressed on-chip memory.
// Independent read and write FSMs; FIXED/INCR bursts up to 256 beats,
// byte strobes, per-beat decode errors and ID echo.
module axi_mem_subordinate #(
    parameter int unsigned AddressWidth       = 20,
    parameter int unsigned TransactionIdWidth = 8,
    parameter int unsigned MemoryBytes        = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    // write address channel
    input  logic [TransactionIdWidth-1:0] awid,
    input  logic [AddressWidth-1:0]       awaddr,
    input  logic [7:0]                    awlen,
    input  logic [2:0]                    awsize,
    input  logic [1:0]                    awburst,
    input  logic                          awlock,
    input  logic [3:0]                    awcache,
    input  logic [2:0]                    awprot,
    input  logic                          awvalid,
    output logic                          awready,
    // write data channel
    input  logic [31:0]                   wdata,
    input  logic [3:0]                    wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    // write response channel
    output logic [TransactionIdWidth-1:0] bid,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    // read address channel
    input  logic [TransactionIdWidth-1:0] arid,
    input  logic [AddressWidth-1:0]       araddr,
    input  logic [7:0]                    arlen,
    input  logic [2:0]                    arsize,
    input  logic [1:0]                    arburst,
    input  logic                          arlock,
    input  logic [3:0]                    arcache,
    input  logic [2:0]                    arprot,
    input  logic                          arvalid,
    output logic                          arready,
    // read data channel
    output logic [TransactionIdWidth-1:0] rid,
    output logic [31:0]                   rdata,
    output logic [1:0]                    rresp,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rready
);

    localparam int unsigned Words         = MemoryBytes / 4;
    localparam int unsigned IdxWidth      = (Words > 1) ? $clog2(Words) : 1;
    localparam int unsigned WordAddrWidth = AddressWidth - 2;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    logic [31:0] mem [Words];

    // Only 32-bit FIXED/INCR bursts are served; anything else is SLVERR for the whole burst.
    function automatic logic bad_request(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || ((burst != BurstFixed) && (burst != BurstIncr));
    endfunction

    // Full-width compare so addresses beyond the memory never alias into it.
    function automatic logic out_of_range(input logic [WordAddrWidth-1:0] word_addr);
        return 64'(word_addr) >= 64'(Words);
    endfunction

    logic unused_inputs;
    assign unused_inputs = ^{awlock, awcache, awprot, arlock, arcache, arprot,
                             awaddr[1:0], araddr[1:0]};

    // ---------------- write path ----------------
    w_state_e                 w_state_q;
    logic [WordAddrWidth-1:0] w_addr_q;
    logic [7:0]               w_len_q, w_beat_q;
    logic [1:0]               w_burst_q;
    logic                     w_slverr_q, w_decerr_q;

    logic                     w_fire, w_beat_oor, w_last_beat, w_slverr_d, w_decerr_d, mem_we;
    logic [WordAddrWidth-1:0] w_next_addr;

    // Per-beat write decode and sticky error accumulation.
    always_comb begin
        w_fire      = wvalid && wready;
        w_beat_oor  = out_of_range(w_addr_q);
        w_last_beat = (w_beat_q == w_len_q);
        w_slverr_d  = w_slverr_q || (wlast != w_last_beat);
        w_decerr_d  = w_decerr_q || w_beat_oor;
        w_next_addr = (w_burst_q == BurstIncr) ? w_addr_q + WordAddrWidth'(1) : w_addr_q;
        mem_we      = w_fire && !w_slverr_q && !w_beat_oor && !rst;
    end

    // Memory write port with byte-lane strobes; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr_q[IdxWidth-1:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Write FSM: AW accept, W beats, B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= WIdle;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= RespOkay;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_beat_q   <= '0;
            w_burst_q  <= BurstFixed;
            w_slverr_q <= 1'b0;
            w_decerr_q <= 1'b0;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        bid        <= awid;
                        w_addr_q   <= awaddr[AddressWidth-1:2];
                        w_len_q    <= awlen;
                        w_beat_q   <= '0;
                        w_burst_q  <= awburst;
                        w_slverr_q <= bad_request(awsize, awburst);
                        w_decerr_q <= 1'b0;
                        w_state_q  <= WData;
                    end
                end
                WData: begin
                    if (w_fire) begin
                        w_slverr_q <= w_slverr_d;
                        w_decerr_q <= w_decerr_d;
                        if (w_last_beat) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bresp     <= w_slverr_d ? RespSlvErr :
                                         w_decerr_d ? RespDecErr : RespOkay;
                            w_state_q <= WResp;
                        end else begin
                            w_beat_q <= w_beat_q + 8'd1;
                            w_addr_q <= w_next_addr;
                        end
                    end
                end
                WResp: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready   <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_e                 r_state_q;
    logic [WordAddrWidth-1:0] r_addr_q;
    logic [7:0]               r_len_q, r_beat_q;
    logic [1:0]               r_burst_q;
    logic                     r_err_q;

    logic [WordAddrWidth-1:0] r_next_addr, ld_addr;
    logic                     ld_err;
    logic [31:0]              ld_data;
    logic [1:0]               ld_resp;

    // Select the beat to load next (beat 0 from AR, else the following beat) and fetch it.
    always_comb begin
        r_next_addr = (r_burst_q == BurstIncr) ? r_addr_q + WordAddrWidth'(1) : r_addr_q;
        ld_addr     = (r_state_q == RIdle) ? araddr[AddressWidth-1:2] : r_next_addr;
        ld_err      = (r_state_q == RIdle) ? bad_request(arsize, arburst) : r_err_q;
        ld_data     = '0;
        ld_resp     = RespOkay;
        if (ld_err) begin
            ld_resp = RespSlvErr;
        end else if (out_of_range(ld_addr)) begin
            ld_resp = RespDecErr;
        end else begin
            ld_data = mem[ld_addr[IdxWidth-1:0]];
        end
    end

    // Read FSM: AR accept, then one registered beat per R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rid       <= '0;
            rdata     <= '0;
            rresp     <= RespOkay;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_burst_q <= BurstFixed;
            r_err_q   <= 1'b0;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready   <= 1'b0;
                        rvalid    <= 1'b1;
                        rid       <= arid;
                        rdata     <= ld_data;
                        rresp     <= ld_resp;
                        rlast     <= (arlen == 8'd0);
                        r_addr_q  <= ld_addr;
                        r_len_q   <= arlen;
                        r_beat_q  <= '0;
                        r_burst_q <= arburst;
                        r_err_q   <= ld_err;
                        r_state_q <= RData;
                    end
                end
                RData: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            rdata     <= '0;
                            rresp     <= RespOkay;
                            arready   <= 1'b1;
                            r_state_q <= RIdle;
                        end else begin
                            r_beat_q <= r_beat_q + 8'd1;
                            r_addr_q <= r_next_addr;
                            rdata    <= ld_data;
                            rresp    <= ld_resp;
                            rlast    <= ((r_beat_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_subordinate.sv
// Directed self-checking bench for axi_mem_subordinate.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_mem_subordinate;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awid, arid, bid, rid;
    logic [19:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    axi_mem_subordinate #(
        .AddressWidth       (20),
        .TransactionIdWidth (8),
        .MemoryBytes        (4096)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awsize  (awsize),
        .awburst (awburst),
        .awlock  (awlock),
        .awcache (awcache),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arsize  (arsize),
        .arburst (arburst),
        .arlock  (arlock),
        .arcache (arcache),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One write burst; data beat i is data[32*i +: 32], wlast for beat i is last_pat[i].
    task automatic write_burst(input string tag, input logic [7:0] id, input logic [19:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [127:0] data,
                               input logic [3:0] strb, input logic [3:0] last_pat,
                               input logic [1:0] exp_resp);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_awready"}, 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        check({tag, "_wready_after_aw"}, 32'(wready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata = data[32*i +: 32]; wstrb = strb; wlast = last_pat[i]; wvalid = 1'b1;
            n = 0;
            while (!wready && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
            if (i < int'(len)) check({tag, "_no_early_bvalid"}, 32'(bvalid), 32'd0);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        check({tag, "_bid"}, 32'(bid), 32'(id));
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        @(negedge clk);
        check({tag, "_bresp_held"}, 32'({bvalid, bresp}), 32'({1'b1, exp_resp}));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_bvalid_clr"}, 32'(bvalid), 32'd0);
        check({tag, "_awready_after_b"}, 32'(awready), 32'd1);
    endtask

    // One read burst; expected beat i is data[32*i +: 32] / resp[2*i +: 2].
    task automatic read_burst(input string tag, input logic [7:0] id, input logic [19:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [127:0] data,
                              input logic [7:0] resp, input int stall_beat, input int stall_cycles);
        int n;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_arready"}, 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            check({tag, "_rid"}, 32'(rid), 32'(id));
            check({tag, "_rdata"}, rdata, data[32*i +: 32]);
            check({tag, "_rresp"}, 32'(rresp), 32'(resp[2*i +: 2]));
            check({tag, "_rlast"}, 32'(rlast), (i == int'(len)) ? 32'd1 : 32'd0);
            if (i == stall_beat) begin
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    check({tag, "_stall_rdata"}, rdata, data[32*i +: 32]);
                    check({tag, "_stall_rvalid_rlast"}, 32'({rvalid, rlast}),
                          32'({1'b1, (i == int'(len))}));
                end
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check({tag, "_rvalid_clr"}, 32'(rvalid), 32'd0);
        check({tag, "_arready_after_r"}, 32'(arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
        awlock = 1'b0; awcache = '0; awprot = '0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
        arlock = 1'b0; arcache = '0; arprot = '0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'({awready, arready, wready}), 32'd0);
        check("rst_valid", 32'({bvalid, rvalid, rlast}), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_ids", 32'({bid, rid}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_awready_low", 32'({awready, arready}), 32'd0);
        @(negedge clk);
        check("rst_release_ready", 32'({awready, arready}), 32'b11);

        // Single word write and readback.
        write_burst("w1", 8'h05, 20'h00010, 8'd0, 3'b010, 2'b01, {96'd0, 32'hDEADBEEF},
                    4'b1111, 4'b0001, 2'b00);
        read_burst("r1", 8'h05, 20'h00010, 8'd0, 3'b010, 2'b01, {96'd0, 32'hDEADBEEF},
                   8'h00, -1, 0);

        // Partial strobes: lanes 0 and 2 only.
        write_burst("w2", 8'h06, 20'h00010, 8'd0, 3'b010, 2'b01, {96'd0, 32'h11223344},
                    4'b0101, 4'b0001, 2'b00);
        read_burst("r2", 8'hA5, 20'h00010, 8'd0, 3'b010, 2'b01, {96'd0, 32'hDE22BE44},
                   8'h00, -1, 0);

        // INCR 4-beat write; read back with a 3-cycle stall on beat 1.
        write_burst("w3", 8'h07, 20'h00020, 8'd3, 3'b010, 2'b01,
                    {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 4'b1000, 2'b00);
        read_burst("r3", 8'h3C, 20'h00020, 8'd3, 3'b010, 2'b01,
                   {32'd4, 32'd3, 32'd2, 32'd1}, 8'h00, 1, 3);

        // Burst running off the end of memory.
        write_burst("w4", 8'h10, 20'h00FFC, 8'd1, 3'b010, 2'b01,
                    {64'd0, 32'hBBBB0002, 32'hAAAA0001}, 4'b1111, 4'b0010, 2'b11);
        read_burst("r4", 8'h11, 20'h00FFC, 8'd1, 3'b010, 2'b01,
                   {64'd0, 32'h0, 32'hAAAA0001}, 8'b0000_1100, -1, 0);

        // Unsupported size and WRAP burst: SLVERR, memory untouched.
        write_burst("w5", 8'h20, 20'h00010, 8'd0, 3'b000, 2'b01, {96'd0, 32'hFFFFFFFF},
                    4'b1111, 4'b0001, 2'b10);
        read_burst("r5", 8'h21, 20'h00010, 8'd0, 3'b010, 2'b01, {96'd0, 32'hDE22BE44},
                   8'h00, -1, 0);
        write_burst("w6", 8'h22, 20'h00020, 8'd0, 3'b010, 2'b10, {96'd0, 32'hFFFFFFFF},
                    4'b1111, 4'b0001, 2'b10);
        read_burst("r6", 8'h23, 20'h00020, 8'd0, 3'b010, 2'b01, {96'd0, 32'd1},
                   8'h00, -1, 0);

        // Misplaced wlast: burst still runs two beats, then SLVERR.
        write_burst("w7", 8'h30, 20'h00030, 8'd1, 3'b010, 2'b01,
                    {64'd0, 32'h66, 32'h55}, 4'b1111, 4'b0001, 2'b10);

        // Unsupported read size: zero data, SLVERR on every beat.
        read_burst("r8", 8'h40, 20'h00020, 8'd1, 3'b000, 2'b01, 128'd0,
                   8'b0000_1010, -1, 0);

        // FIXED burst repeats the same word.
        read_burst("r9", 8'h41, 20'h00024, 8'd2, 3'b010, 2'b00,
                   {32'd0, 32'd2, 32'd2, 32'd2}, 8'h00, -1, 0);

        // Reset asserted on beat 2 of a 4-beat read.
        arid = 8'h50; araddr = 20'h00020; arlen = 8'd3; arsize = 3'b010; arburst = 2'b01;
        arvalid = 1'b1;
        check("rr_arready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rr_beat0", rdata, 32'd1);
        rready = 1'b1;
        repeat (2) @(negedge clk);
        rready = 1'b0;
        check("rr_beat2", rdata, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("rr_rvalid_dropped", 32'(rvalid), 32'd0);
        check("rr_ready_low_in_rst", 32'({arready, awready}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rr_arready_back", 32'(arready), 32'd1);
        read_burst("r10", 8'h51, 20'h00024, 8'd0, 3'b010, 2'b01, {96'd0, 32'd2},
                   8'h00, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
